// File: rtl/spi_txn_scheduler_pkg.sv
// ============================================================================
// Module      : spi_txn_scheduler_pkg
// Description : Shared types and constants for the SPI transaction scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_txn_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT    = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_RESP     = 3'd4,
        ST_GAP      = 3'd5
    } sched_state_t;

    // Chip select is active-low on the master side
    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    localparam int SCHED_GAP_CYCLES  = 4;
    localparam int SCHED_TIMEOUT_CYC = 2048;

endpackage

`default_nettype wire

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : spi_txn_scheduler_rr_arbiter
// Description : Round-robin one-hot arbiter; pointer moves past winner on accept.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_txn_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_any
);

    localparam int c_POS_W = PTR_W + 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [c_POS_W-1:0] w_pos;

    // Scan from the pointer, wrapping modulo NUM_REQ; first hit wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_pos       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, r_ptr} + c_POS_W'(i);
            if (w_pos >= c_POS_W'(NUM_REQ)) begin
                w_pos = w_pos - c_POS_W'(NUM_REQ);
            end
            if (!o_any && i_req[w_pos[PTR_W-1:0]]) begin
                o_any                      = 1'b1;
                o_grant[w_pos[PTR_W-1:0]]  = 1'b1;
                o_grant_idx                = w_pos[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= (o_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + PTR_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_txn_scheduler.sv
// ============================================================================
// Module      : spi_txn_scheduler
// Description : Arbitrates requester frames onto a single SPI master and
//               returns the captured response to the winning requester.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_txn_scheduler
    import spi_txn_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int CMD_W       = 8,
    parameter int ADDR_W      = 8,
    parameter int PAYLOAD_W   = 8,
    parameter int RESP_W      = 7,
    parameter int GAP_CYCLES  = SCHED_GAP_CYCLES,
    parameter int TIMEOUT_CYC = SCHED_TIMEOUT_CYC
) (
    input  logic                              sysclk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*CMD_W-1:0]          req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0]         req_addr,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]      req_payload,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [RESP_W-1:0]                 rsp_data,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic                              spi_tx_enb,
    output logic [CMD_W+ADDR_W+PAYLOAD_W-1:0] spi_i_frame,
    input  logic                              spi_cs,
    input  logic [RESP_W-1:0]                 spi_o_frame
);

    localparam int c_FRAME_W  = CMD_W + ADDR_W + PAYLOAD_W;
    localparam int c_PTR_W    = $clog2(NUM_REQ);
    localparam int c_CNT_W    = $clog2(TIMEOUT_CYC);
    localparam int c_GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sched_state_t         r_state;
    sched_state_t         w_next;
    logic [c_PTR_W-1:0]   r_win;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_any;
    logic                 w_accept;
    logic [c_FRAME_W-1:0] w_sel_frame;
    logic [c_FRAME_W-1:0] r_frame;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [RESP_W-1:0]    r_rsp_data;
    logic                 r_rsp_timeout;
    logic                 w_cnt_hit;
    logic                 w_done;
    logic                 w_abort;

    spi_txn_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_arb (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .i_req       (req_valid),
        .i_accept    (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_accept = (r_state == ST_GRANT) && w_any;

    always_comb begin
        w_sel_frame = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_frame = {req_cmd[i*CMD_W +: CMD_W],
                               req_addr[i*ADDR_W +: ADDR_W],
                               req_payload[i*PAYLOAD_W +: PAYLOAD_W]};
            end
        end
    end

    // Normal completion wins over a timeout landing on the same cycle
    assign w_cnt_hit = (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
    assign w_done    = (r_state == ST_WAIT_END) && (spi_cs == CS_DEASSERT);
    assign w_abort   = ((r_state == ST_LAUNCH) || ((r_state == ST_WAIT_END) && !w_done)) && w_cnt_hit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (|req_valid) w_next = ST_GRANT;
            ST_GRANT:    w_next = w_any ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: begin
                if (w_abort) begin
                    w_next = ST_RESP;
                end else if (spi_cs == CS_ASSERT) begin
                    w_next = ST_WAIT_END;
                end
            end
            ST_WAIT_END: if (w_done || w_abort) w_next = ST_RESP;
            ST_RESP:     w_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:      if (r_cnt == c_CNT_W'(c_GAP_LAST)) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_win         <= '0;
            r_frame       <= '0;
            r_cnt         <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_frame <= w_sel_frame;
                r_win   <= w_grant_idx;
            end
            // One saturating counter serves both the launch timeout and the gap
            if ((r_state == ST_GRANT) || (r_state == ST_RESP)) begin
                r_cnt <= '0;
            end else if (((r_state == ST_LAUNCH) || (r_state == ST_WAIT_END) || (r_state == ST_GAP))
                         && (r_cnt != '1)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_done) begin
                r_rsp_data    <= spi_o_frame;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign rsp_valid[g] = (r_state == ST_RESP) && (r_win == c_PTR_W'(g));
        assign req_ready[g] = (r_state == ST_GRANT) && w_grant[g];
    end

    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != ST_IDLE);
    assign spi_tx_enb  = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_END);
    assign spi_i_frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_scheduler.sv
// ============================================================================
// Module      : tb_spi_txn_scheduler
// Description : Scoreboard bench for spi_txn_scheduler with a behavioural
//               SPI master stand-in.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_txn_scheduler;
    import spi_txn_scheduler_pkg::*;

    localparam int GAP       = 4;
    localparam int TMO       = 2048;
    localparam int FRAME_CYC = 30;

    typedef struct packed {
        logic [1:0] onehot;
        logic [6:0] data;
        logic       tmo;
    } rsp_t;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_cmd;
    logic [15:0] req_addr;
    logic [15:0] req_payload;
    logic [1:0]  rsp_valid;
    logic [6:0]  rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic        spi_tx_enb;
    logic [23:0] spi_i_frame;
    logic        spi_cs;
    logic [6:0]  spi_o_frame;

    logic        mock_override;
    logic        mock_stuck;
    logic [23:0] mock_miso;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [23:0] q_launch[$];
    rsp_t        q_rsp[$];

    always #4 sysclk = ~sysclk;

    spi_txn_scheduler #(
        .NUM_REQ     (2),
        .CMD_W       (8),
        .ADDR_W      (8),
        .PAYLOAD_W   (8),
        .RESP_W      (7),
        .GAP_CYCLES  (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_payload (req_payload),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .spi_tx_enb  (spi_tx_enb),
        .spi_i_frame (spi_i_frame),
        .spi_cs      (spi_cs),
        .spi_o_frame (spi_o_frame)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        req_cmd[r*8 +: 8]     = c;
        req_addr[r*8 +: 8]    = a;
        req_payload[r*8 +: 8] = p;
    endtask

    // Waits for the grant; returns just after the accepting edge
    task automatic wait_accept(input int r);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge sysclk);
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL grant_wait req%0d: ready never seen, expected within 300 cycles", r);
        end
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_drain(input int limit);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < limit; t++) begin
            @(negedge sysclk);
            if (q_rsp.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, busy=%0b, expected 0 and idle", q_rsp.size(), busy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
    endtask

    // Master stand-in: asserts cs one cycle after tx_enb, holds it a frame, returns miso[7:1]
    initial begin : master_mock
        logic [23:0] miso;
        spi_cs      = CS_DEASSERT;
        spi_o_frame = '0;
        forever begin
            @(posedge sysclk);
            #1;
            if (spi_tx_enb === 1'b1 && spi_cs == CS_DEASSERT) begin
                miso   = mock_override ? mock_miso : ~spi_i_frame;
                spi_cs = CS_ASSERT;
                if (mock_stuck) begin
                    for (int t = 0; t < 5000 && spi_tx_enb; t++) begin
                        @(posedge sysclk);
                        #1;
                    end
                end else begin
                    repeat (FRAME_CYC) @(posedge sysclk);
                    #1;
                    spi_o_frame = miso[7:1];
                end
                spi_cs = CS_DEASSERT;
                for (int t = 0; t < 100 && spi_tx_enb; t++) begin
                    @(posedge sysclk);
                    #1;
                end
            end
        end
    end

    initial begin : monitor
        logic        prev_enb;
        int          enb_run;
        int          gap_run;
        bit          seen_rsp;
        rsp_t        e;
        logic [23:0] f;
        prev_enb = 1'b0;
        enb_run  = 0;
        gap_run  = 0;
        seen_rsp = 1'b0;
        forever begin
            @(negedge sysclk);
            if (spi_tx_enb === 1'b1 && !prev_enb) begin
                if (q_launch.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL launch_unexpected: frame %h launched, none expected", spi_i_frame);
                end else begin
                    f = q_launch.pop_front();
                    chk("launch_frame", 32'(spi_i_frame), 32'(f));
                end
                if (seen_rsp) begin
                    n_chk++;
                    if (gap_run < GAP + 2) begin
                        n_fail++;
                        $display("FAIL gap: %0d idle cycles after response, expected >= %0d", gap_run, GAP + 2);
                    end
                end
                enb_run = 0;
            end
            if (rsp_valid !== 2'b00 && rsp_valid !== 2'bxx) begin
                if (q_rsp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, no response expected", rsp_valid, rsp_data);
                end else begin
                    e = q_rsp.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                    chk("rsp_tx_enb_low", 32'(spi_tx_enb), 32'(0));
                    if (e.tmo) chk("timeout_len", 32'(enb_run), 32'(TMO));
                end
                seen_rsp = 1'b1;
                gap_run  = 0;
            end else begin
                gap_run++;
            end
            if (spi_tx_enb === 1'b1) enb_run++;
            prev_enb = (spi_tx_enb === 1'b1);
        end
    end

    initial begin : watchdog
        #160000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        req_valid     = '0;
        req_cmd       = '0;
        req_addr      = '0;
        req_payload   = '0;
        mock_override = 1'b0;
        mock_stuck    = 1'b0;
        mock_miso     = '0;
        rst_n         = 1'b0;

        // T1: reset state
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_tx_enb", 32'(spi_tx_enb), 32'(0));
        chk("rst_i_frame", 32'(spi_i_frame), 32'(0));
        @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;

        // T2: single request on req0, with latency checks
        q_launch.push_back(24'h80A0D1);
        q_rsp.push_back('{onehot: 2'b01, data: 7'h17, tmo: 1'b0});
        set_req(0, 8'h80, 8'hA0, 8'hD1);
        req_valid[0] = 1'b1;
        @(negedge sysclk);
        chk("t2_ready_cycle0", 32'(req_ready), 32'(0));
        @(negedge sysclk);
        chk("t2_ready_cycle1", 32'(req_ready), 32'(2'b01));
        chk("t2_busy", 32'(busy), 32'(1));
        @(posedge sysclk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge sysclk);
        chk("t2_tx_enb_cycle2", 32'(spi_tx_enb), 32'(1));
        wait_drain(200);

        // T4: response capture from a fixed miso word on req1
        mock_override = 1'b1;
        mock_miso     = 24'h40E898;
        q_launch.push_back(24'h81B000);
        q_rsp.push_back('{onehot: 2'b10, data: 7'h4C, tmo: 1'b0});
        set_req(1, 8'h81, 8'hB0, 8'h00);
        req_valid[1] = 1'b1;
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_drain(200);
        chk("t4_rsp_data_hold", 32'(rsp_data), 32'(7'h4C));
        mock_override = 1'b0;

        // T5: cs stuck asserted -> timeout abort
        mock_stuck = 1'b1;
        q_launch.push_back(24'h0FF055);
        q_rsp.push_back('{onehot: 2'b01, data: 7'h00, tmo: 1'b1});
        set_req(0, 8'h0F, 8'hF0, 8'h55);
        req_valid[0] = 1'b1;
        wait_accept(0);
        req_valid[0] = 1'b0;
        wait_drain(3000);
        mock_stuck = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;

        // T3: contention from reset pointer -> 0,1,0,1
        do_reset();
        q_launch.push_back(24'h112233);
        q_launch.push_back(24'h556677);
        q_launch.push_back(24'h112234);
        q_launch.push_back(24'h556678);
        q_rsp.push_back('{onehot: 2'b01, data: 7'h66, tmo: 1'b0});
        q_rsp.push_back('{onehot: 2'b10, data: 7'h44, tmo: 1'b0});
        q_rsp.push_back('{onehot: 2'b01, data: 7'h65, tmo: 1'b0});
        q_rsp.push_back('{onehot: 2'b10, data: 7'h43, tmo: 1'b0});
        fork
            begin
                set_req(0, 8'h11, 8'h22, 8'h33);
                req_valid[0] = 1'b1;
                wait_accept(0);
                set_req(0, 8'h11, 8'h22, 8'h34);
                wait_accept(0);
                req_valid[0] = 1'b0;
            end
            begin
                set_req(1, 8'h55, 8'h66, 8'h77);
                req_valid[1] = 1'b1;
                wait_accept(1);
                set_req(1, 8'h55, 8'h66, 8'h78);
                wait_accept(1);
                req_valid[1] = 1'b0;
            end
        join
        wait_drain(400);

        // T6: reset in WAIT_END, no response, then normal service
        q_launch.push_back(24'hA55A3C);
        set_req(0, 8'hA5, 8'h5A, 8'h3C);
        req_valid[0] = 1'b1;
        wait_accept(0);
        req_valid[0] = 1'b0;
        for (int t = 0; t < 50 && spi_cs != CS_ASSERT; t++) @(negedge sysclk);
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("t6_pre_tx_enb", 32'(spi_tx_enb), 32'(1));
        @(posedge sysclk);
        #1;
        rst_n = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        chk("t6_rst_tx_enb", 32'(spi_tx_enb), 32'(0));
        chk("t6_rst_busy", 32'(busy), 32'(0));
        @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 100 && spi_cs != CS_DEASSERT; t++) @(negedge sysclk);
        repeat (4) @(posedge sysclk);
        #1;
        q_launch.push_back(24'hC30FF0);
        q_rsp.push_back('{onehot: 2'b10, data: 7'h07, tmo: 1'b0});
        set_req(1, 8'hC3, 8'h0F, 8'hF0);
        req_valid[1] = 1'b1;
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_drain(200);

        repeat (5) @(posedge sysclk);
        chk("launch_queue_empty", 32'(q_launch.size()), 32'(0));
        chk("rsp_queue_empty", 32'(q_rsp.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
